// File: rtl/vend_pkg.sv
// rtl/vend_pkg.sv - shared encodings for the vending controller: coin values, FSM states, error codes.
package vend_pkg;

    typedef enum logic [1:0] {
        COIN_500  = 2'd0,
        COIN_1000 = 2'd1,
        COIN_2000 = 2'd2,
        COIN_5000 = 2'd3
    } coin_type_t;

    localparam logic [15:0] COIN_VAL_500  = 16'd500;
    localparam logic [15:0] COIN_VAL_1000 = 16'd1000;
    localparam logic [15:0] COIN_VAL_2000 = 16'd2000;
    localparam logic [15:0] COIN_VAL_5000 = 16'd5000;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_VEND   = 2'd2,
        ST_CHANGE = 2'd3
    } state_t;

    localparam logic [1:0] ERR_NONE      = 2'd0;
    localparam logic [1:0] ERR_SOLD_OUT  = 2'd1;
    localparam logic [1:0] ERR_NO_CREDIT = 2'd2;
    localparam logic [1:0] ERR_BAD_ADDR  = 2'd3;

    function automatic logic [15:0] coin_value(input logic [1:0] coin);
        case (coin)
            COIN_500:  coin_value = COIN_VAL_500;
            COIN_1000: coin_value = COIN_VAL_1000;
            COIN_2000: coin_value = COIN_VAL_2000;
            default:   coin_value = COIN_VAL_5000;
        endcase
    endfunction

endpackage

// File: rtl/vend_price_calc.sv
// rtl/vend_price_calc.sv - effective slot price; VEND_DISCOUNT_EN enables the 9/16 overstock discount.
module vend_price_calc
    import vend_pkg::*;
#(
    parameter int N_PRODUCTS      = 8,
    parameter int CREDIT_W        = 16,
    parameter int STOCK_W         = 8,
    parameter int PRICE_STEP      = 500,
    parameter int DISCOUNT_THRESH = 10
) (
    input  logic [$clog2(N_PRODUCTS)-1:0] slot,
    input  logic [STOCK_W-1:0]            stock,
    output logic [CREDIT_W-1:0]           price
);

    logic [CREDIT_W-1:0] base;

    assign base = CREDIT_W'((32'(slot) + 32'd1) * 32'(PRICE_STEP));

`ifdef VEND_DISCOUNT_EN
    // Rounds up: ceil(base*9/16) == (base*9 + 15) >> 4.
    logic [2*CREDIT_W-1:0] scaled;
    logic                  unused_scaled;

    assign scaled        = (2*CREDIT_W)'(base) * (2*CREDIT_W)'(9) + (2*CREDIT_W)'(15);
    assign unused_scaled = ^{scaled[2*CREDIT_W-1:CREDIT_W+4], scaled[3:0]};
    assign price         = (stock > STOCK_W'(DISCOUNT_THRESH)) ? scaled[CREDIT_W+3:4] : base;
`else
    localparam int unused_thresh = DISCOUNT_THRESH;
    logic unused_stock;

    assign unused_stock = ^stock;
    assign price        = base;
`endif

endmodule

// File: rtl/vend_controller.sv
// rtl/vend_controller.sv - coin credit, per-slot stock and vend/change sequencing; VEND_DISCOUNT_EN selects discounted pricing.
module vend_controller
    import vend_pkg::*;
#(
    parameter int N_PRODUCTS      = 8,
    parameter int CREDIT_W        = 16,
    parameter int STOCK_W         = 8,
    parameter int PRICE_STEP      = 500,
    parameter int INIT_STOCK      = 10,
    parameter int CREDIT_MAX      = 20000,
    parameter int DISCOUNT_THRESH = 10
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          coin_valid,
    input  logic [1:0]                    coin_type,
    output logic                          coin_accept,
    output logic                          coin_reject,
    input  logic                          sel_valid,
    input  logic [$clog2(N_PRODUCTS)-1:0] sel_addr,
    input  logic                          cancel,
    input  logic                          restock_valid,
    input  logic [$clog2(N_PRODUCTS)-1:0] restock_addr,
    input  logic [STOCK_W-1:0]            restock_qty,
    output logic                          vend_valid,
    output logic [$clog2(N_PRODUCTS)-1:0] vend_addr,
    output logic                          change_valid,
    output logic [CREDIT_W-1:0]           change_amount,
    output logic                          err_valid,
    output logic [1:0]                    err_code,
    output logic [CREDIT_W-1:0]           credit,
    output logic                          busy
);

    localparam int                AW         = $clog2(N_PRODUCTS);
    localparam logic [AW:0]       N_LIM      = (AW+1)'(N_PRODUCTS);
    localparam logic [CREDIT_W:0] CREDIT_LIM = (CREDIT_W+1)'(CREDIT_MAX);

    state_t               state_q, state_d;
    logic [CREDIT_W-1:0]  credit_q, credit_d;
    logic [STOCK_W-1:0]   stock_q [N_PRODUCTS];
    logic [STOCK_W-1:0]   stock_d [N_PRODUCTS];

    logic                 coin_accept_d, coin_reject_d, vend_valid_d, change_valid_d;
    logic                 err_valid_d, busy_d, sel_ok, sel_addr_ok, restock_hit;
    logic [AW-1:0]        vend_addr_d;
    logic [CREDIT_W-1:0]  change_amount_d, price;
    logic [1:0]           err_code_d;
    logic [CREDIT_W:0]    coin_sum;
    logic [STOCK_W-1:0]   sel_stock;
    logic [STOCK_W:0]     stock_sum;

    vend_price_calc #(
        .N_PRODUCTS      (N_PRODUCTS),
        .CREDIT_W        (CREDIT_W),
        .STOCK_W         (STOCK_W),
        .PRICE_STEP      (PRICE_STEP),
        .DISCOUNT_THRESH (DISCOUNT_THRESH)
    ) u_price (
        .slot  (sel_addr),
        .stock (sel_stock),
        .price (price)
    );

    assign sel_addr_ok = {1'b0, sel_addr} < N_LIM;
    assign restock_hit = restock_valid && ({1'b0, restock_addr} < N_LIM);
    assign credit      = credit_q;

    always_comb begin
        sel_stock = '0;
        for (int i = 0; i < N_PRODUCTS; i++) begin
            if (sel_addr == AW'(i)) sel_stock = stock_q[i];
        end
    end

    always_comb begin
        state_d         = state_q;
        credit_d        = credit_q;
        coin_accept_d   = 1'b0;
        coin_reject_d   = 1'b0;
        vend_valid_d    = 1'b0;
        vend_addr_d     = '0;
        change_valid_d  = 1'b0;
        change_amount_d = '0;
        err_valid_d     = 1'b0;
        err_code_d      = ERR_NONE;
        sel_ok          = 1'b0;
        stock_sum       = '0;
        coin_sum        = {1'b0, credit_q} + (CREDIT_W+1)'(coin_value(coin_type));

        unique case (state_q)
            ST_IDLE, ST_HOLD: begin
                if (cancel) begin
                    coin_reject_d = coin_valid;
                    if (state_q == ST_HOLD) begin
                        state_d         = ST_CHANGE;
                        change_valid_d  = 1'b1;
                        change_amount_d = credit_q;
                    end
                end else if (sel_valid) begin
                    coin_reject_d = coin_valid;
                    if (!sel_addr_ok) begin
                        err_valid_d = 1'b1;
                        err_code_d  = ERR_BAD_ADDR;
                    end else if (sel_stock == '0) begin
                        err_valid_d = 1'b1;
                        err_code_d  = ERR_SOLD_OUT;
                    end else if (credit_q < price) begin
                        err_valid_d = 1'b1;
                        err_code_d  = ERR_NO_CREDIT;
                    end else begin
                        sel_ok       = 1'b1;
                        credit_d     = credit_q - price;
                        state_d      = ST_VEND;
                        vend_valid_d = 1'b1;
                        vend_addr_d  = sel_addr;
                    end
                end else if (coin_valid) begin
                    if (coin_sum <= CREDIT_LIM) begin
                        coin_accept_d = 1'b1;
                        credit_d      = coin_sum[CREDIT_W-1:0];
                        state_d       = ST_HOLD;
                    end else begin
                        coin_reject_d = 1'b1;
                    end
                end
            end
            // The change pulse is emitted on entry to CHANGE; CHANGE itself clears the credit.
            ST_VEND: begin
                coin_reject_d = coin_valid;
                state_d       = ST_CHANGE;
                if (credit_q != '0) begin
                    change_valid_d  = 1'b1;
                    change_amount_d = credit_q;
                end
            end
            ST_CHANGE: begin
                coin_reject_d = coin_valid;
                credit_d      = '0;
                state_d       = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Restock and vend decrement may hit the same slot; the net sum saturates.
        for (int i = 0; i < N_PRODUCTS; i++) begin
            stock_sum = {1'b0, stock_q[i]};
            if (restock_hit && restock_addr == AW'(i)) stock_sum = stock_sum + {1'b0, restock_qty};
            if (sel_ok && sel_addr == AW'(i)) stock_sum = stock_sum - (STOCK_W+1)'(1);
            stock_d[i] = stock_sum[STOCK_W] ? '1 : stock_sum[STOCK_W-1:0];
        end

        busy_d = (state_d == ST_VEND) || (state_d == ST_CHANGE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            credit_q      <= '0;
            for (int i = 0; i < N_PRODUCTS; i++) stock_q[i] <= STOCK_W'(INIT_STOCK);
            coin_accept   <= 1'b0;
            coin_reject   <= 1'b0;
            vend_valid    <= 1'b0;
            vend_addr     <= '0;
            change_valid  <= 1'b0;
            change_amount <= '0;
            err_valid     <= 1'b0;
            err_code      <= ERR_NONE;
            busy          <= 1'b0;
        end else begin
            state_q       <= state_d;
            credit_q      <= credit_d;
            for (int i = 0; i < N_PRODUCTS; i++) stock_q[i] <= stock_d[i];
            coin_accept   <= coin_accept_d;
            coin_reject   <= coin_reject_d;
            vend_valid    <= vend_valid_d;
            vend_addr     <= vend_addr_d;
            change_valid  <= change_valid_d;
            change_amount <= change_amount_d;
            err_valid     <= err_valid_d;
            err_code      <= err_code_d;
            busy          <= busy_d;
        end
    end

endmodule

// File: tb/tb_vend_controller.sv
// tb/tb_vend_controller.sv - table-driven bench for vend_controller; expectations follow VEND_DISCOUNT_EN.
module tb_vend_controller;

`ifdef VEND_DISCOUNT_EN
    localparam int P0D = 282;
    localparam int P1D = 563;
`else
    localparam int P0D = 500;
    localparam int P1D = 1000;
`endif

    typedef struct {
        int cv, ct, sv, sa, cn, rv, ra, rq;
        int acc, rej, vv, va, chv, cha, ev, ec, cr, bsy;
    } row_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        coin_valid, sel_valid, cancel, restock_valid;
    logic [1:0]  coin_type;
    logic [2:0]  sel_addr, restock_addr;
    logic [7:0]  restock_qty;

    logic        coin_accept, coin_reject, vend_valid, change_valid, err_valid, busy;
    logic [2:0]  vend_addr;
    logic [15:0] change_amount, credit;
    logic [1:0]  err_code;

    logic        d1_coin_accept, d1_coin_reject, d1_vend_valid, d1_change_valid, d1_err_valid, d1_busy;
    logic [2:0]  d1_vend_addr;
    logic [15:0] d1_change_amount, d1_credit;
    logic [1:0]  d1_err_code;

    int   checks = 0;
    int   errors = 0;
    row_t tbl[$];
    row_t r;

    always #5 clock = ~clock;

    vend_controller u_dut (
        .clock(clock), .reset(reset),
        .coin_valid(coin_valid), .coin_type(coin_type),
        .coin_accept(coin_accept), .coin_reject(coin_reject),
        .sel_valid(sel_valid), .sel_addr(sel_addr), .cancel(cancel),
        .restock_valid(restock_valid), .restock_addr(restock_addr), .restock_qty(restock_qty),
        .vend_valid(vend_valid), .vend_addr(vend_addr),
        .change_valid(change_valid), .change_amount(change_amount),
        .err_valid(err_valid), .err_code(err_code),
        .credit(credit), .busy(busy)
    );

    vend_controller #(.N_PRODUCTS(6), .INIT_STOCK(1)) u_dut1 (
        .clock(clock), .reset(reset),
        .coin_valid(coin_valid), .coin_type(coin_type),
        .coin_accept(d1_coin_accept), .coin_reject(d1_coin_reject),
        .sel_valid(sel_valid), .sel_addr(sel_addr), .cancel(cancel),
        .restock_valid(restock_valid), .restock_addr(restock_addr), .restock_qty(restock_qty),
        .vend_valid(d1_vend_valid), .vend_addr(d1_vend_addr),
        .change_valid(d1_change_valid), .change_amount(d1_change_amount),
        .err_valid(d1_err_valid), .err_code(d1_err_code),
        .credit(d1_credit), .busy(d1_busy)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input int cv, input int ct, input int sv, input int sa, input int cn,
                        input int rv, input int ra, input int rq);
        coin_valid    = 1'(cv);
        coin_type     = 2'(ct);
        sel_valid     = 1'(sv);
        sel_addr      = 3'(sa);
        cancel        = 1'(cn);
        restock_valid = 1'(rv);
        restock_addr  = 3'(ra);
        restock_qty   = 8'(rq);
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        coin_valid = 0; coin_type = 0; sel_valid = 0; sel_addr = 0; cancel = 0;
        restock_valid = 0; restock_addr = 0; restock_qty = 0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        //                cv ct sv sa cn rv ra rq   acc rej vv va chv cha   ev ec cr     bsy
        tbl.push_back(row_t'{1, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0,     0, 0, 500,   0});
        tbl.push_back(row_t'{1, 1, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0,     0, 0, 1500,  0});
        tbl.push_back(row_t'{1, 2, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0,     0, 0, 3500,  0});
        tbl.push_back(row_t'{1, 3, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0,     0, 0, 8500,  0});
        tbl.push_back(row_t'{0, 0, 0, 0, 1, 0, 0, 0,   0, 0, 0, 0, 1, 8500,  0, 0, 8500,  1});
        tbl.push_back(row_t'{0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0,     0, 0, 0,     0});
        tbl.push_back(row_t'{1, 2, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0,     0, 0, 2000,  0});
        tbl.push_back(row_t'{0, 0, 1, 2, 0, 0, 0, 0,   0, 0, 1, 2, 0, 0,     0, 0, 500,   1});
        tbl.push_back(row_t'{0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 1, 500,   0, 0, 500,   1});
        tbl.push_back(row_t'{0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0,     0, 0, 0,     0});
        tbl.push_back(row_t'{1, 1, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0,     0, 0, 1000,  0});
        tbl.push_back(row_t'{0, 0, 1, 3, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0,     1, 2, 1000,  0});
        tbl.push_back(row_t'{0, 0, 0, 0, 1, 0, 0, 0,   0, 0, 0, 0, 1, 1000,  0, 0, 1000,  1});
        tbl.push_back(row_t'{0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0,     0, 0, 0,     0});
        tbl.push_back(row_t'{1, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0,     0, 0, 500,   0});
        tbl.push_back(row_t'{1, 0, 1, 0, 0, 0, 0, 0,   0, 1, 1, 0, 0, 0,     0, 0, 0,     1});
        tbl.push_back(row_t'{1, 1, 0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0, 0,     0, 0, 0,     1});
        tbl.push_back(row_t'{0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0,     0, 0, 0,     0});
        tbl.push_back(row_t'{0, 0, 0, 0, 1, 0, 0, 0,   0, 0, 0, 0, 0, 0,     0, 0, 0,     0});
        tbl.push_back(row_t'{1, 0, 0, 0, 1, 0, 0, 0,   0, 1, 0, 0, 0, 0,     0, 0, 0,     0});
        tbl.push_back(row_t'{0, 0, 1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0,     1, 2, 0,     0});
        tbl.push_back(row_t'{1, 3, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0,     0, 0, 5000,  0});
        tbl.push_back(row_t'{1, 3, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0,     0, 0, 10000, 0});
        tbl.push_back(row_t'{1, 3, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0,     0, 0, 15000, 0});
        tbl.push_back(row_t'{1, 2, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0,     0, 0, 17000, 0});
        tbl.push_back(row_t'{1, 2, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0,     0, 0, 19000, 0});
        tbl.push_back(row_t'{1, 3, 0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0, 0,     0, 0, 19000, 0});
        tbl.push_back(row_t'{1, 1, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0,     0, 0, 20000, 0});
        tbl.push_back(row_t'{1, 0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0, 0,     0, 0, 20000, 0});
        tbl.push_back(row_t'{0, 0, 0, 0, 1, 0, 0, 0,   0, 0, 0, 0, 1, 20000, 0, 0, 20000, 1});
        tbl.push_back(row_t'{0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0,     0, 0, 0,     0});
        tbl.push_back(row_t'{0, 0, 0, 0, 0, 1, 0, 5,   0, 0, 0, 0, 0, 0,     0, 0, 0,     0});
        tbl.push_back(row_t'{1, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0,     0, 0, 500,   0});
        tbl.push_back(row_t'{0, 0, 1, 0, 0, 0, 0, 0,   0, 0, 1, 0, 0, 0,     0, 0, 500-P0D, 1});
        tbl.push_back(row_t'{0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, (P0D != 500) ? 1 : 0, 500-P0D, 0, 0, 500-P0D, 1});
        tbl.push_back(row_t'{0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0,     0, 0, 0,     0});
        tbl.push_back(row_t'{1, 3, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0,     0, 0, 5000,  0});
        tbl.push_back(row_t'{0, 0, 1, 1, 0, 1, 1, 3,   0, 0, 1, 1, 0, 0,     0, 0, 4000,  1});
        tbl.push_back(row_t'{0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 1, 4000,  0, 0, 4000,  1});
        tbl.push_back(row_t'{0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0,     0, 0, 0,     0});
        tbl.push_back(row_t'{0, 0, 0, 0, 0, 1, 2, 250, 0, 0, 0, 0, 0, 0,     0, 0, 0,     0});
        tbl.push_back(row_t'{1, 2, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0,     0, 0, 2000,  0});
        tbl.push_back(row_t'{0, 0, 1, 1, 0, 0, 0, 0,   0, 0, 1, 1, 0, 0,     0, 0, 2000-P1D, 1});
        tbl.push_back(row_t'{0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 1, 2000-P1D, 0, 0, 2000-P1D, 1});
        tbl.push_back(row_t'{0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0,     0, 0, 0,     0});

        do_reset();
        chk("rst_accept", int'(coin_accept), 0);
        chk("rst_vend", int'(vend_valid), 0);
        chk("rst_change", int'(change_valid), 0);
        chk("rst_err", int'(err_valid), 0);
        chk("rst_credit", int'(credit), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_stock0", int'(u_dut.stock_q[0]), 10);

        // Single-unit stock instance (6 slots): sold out, address range, coin with selection.
        step(1, 0, 0, 0, 0, 0, 0, 0); chk("d1_coin", int'(d1_coin_accept), 1);
        chk("d1_credit500", int'(d1_credit), 500);
        step(0, 0, 1, 0, 0, 0, 0, 0); chk("d1_vend", int'(d1_vend_valid), 1);
        step(0, 0, 0, 0, 0, 0, 0, 0); chk("d1_nochange", int'(d1_change_valid), 0);
        step(0, 0, 0, 0, 0, 0, 0, 0); chk("d1_idle_credit", int'(d1_credit), 0);
        step(1, 0, 0, 0, 0, 0, 0, 0); chk("d1_credit2", int'(d1_credit), 500);
        step(0, 0, 1, 0, 0, 0, 0, 0); chk("d1_soldout_code", int'(d1_err_code), 1);
        chk("d1_soldout_valid", int'(d1_err_valid), 1);
        chk("d1_soldout_credit", int'(d1_credit), 500);
        chk("d1_soldout_novend", int'(d1_vend_valid), 0);
        step(0, 0, 1, 7, 0, 0, 0, 0); chk("d1_addr7_code", int'(d1_err_code), 3);
        step(0, 0, 1, 6, 0, 0, 0, 0); chk("d1_addr6_code", int'(d1_err_code), 3);
        step(1, 0, 1, 5, 0, 0, 0, 0); chk("d1_slot5_code", int'(d1_err_code), 2);
        chk("d1_coin_sel_reject", int'(d1_coin_reject), 1);
        chk("d1_coin_sel_credit", int'(d1_credit), 500);
        step(0, 0, 0, 0, 1, 0, 0, 0); chk("d1_cancel_chv", int'(d1_change_valid), 1);
        chk("d1_cancel_amt", int'(d1_change_amount), 500);
        step(0, 0, 0, 0, 0, 0, 0, 0); chk("d1_cancel_idle", int'(d1_credit), 0);

        do_reset();
        for (int i = 0; i < tbl.size(); i++) begin
            r = tbl[i];
            step(r.cv, r.ct, r.sv, r.sa, r.cn, r.rv, r.ra, r.rq);
            chk($sformatf("r%0d_accept", i), int'(coin_accept), r.acc);
            chk($sformatf("r%0d_reject", i), int'(coin_reject), r.rej);
            chk($sformatf("r%0d_vend", i), int'(vend_valid), r.vv);
            chk($sformatf("r%0d_vend_addr", i), int'(vend_addr), r.va);
            chk($sformatf("r%0d_change", i), int'(change_valid), r.chv);
            chk($sformatf("r%0d_change_amt", i), int'(change_amount), r.cha);
            chk($sformatf("r%0d_err", i), int'(err_valid), r.ev);
            chk($sformatf("r%0d_err_code", i), int'(err_code), r.ec);
            chk($sformatf("r%0d_credit", i), int'(credit), r.cr);
            chk($sformatf("r%0d_busy", i), int'(busy), r.bsy);
        end
        chk("stock0", int'(u_dut.stock_q[0]), 13);
        chk("stock1", int'(u_dut.stock_q[1]), 11);
        chk("stock2_sat", int'(u_dut.stock_q[2]), 255);

        // Asynchronous reset in the middle of a vend drops the pending pulses.
        step(1, 1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0, 0); chk("mid_vend_pulse", int'(vend_valid), 1);
        reset = 1'b1;
        #1;
        chk("mid_rst_vend", int'(vend_valid), 0);
        chk("mid_rst_credit", int'(credit), 0);
        chk("mid_rst_busy", int'(busy), 0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        step(0, 0, 0, 0, 0, 0, 0, 0);
        chk("mid_rst_nochange", int'(change_valid), 0);
        chk("mid_rst_stock0", int'(u_dut.stock_q[0]), 10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vend_controller.md
# vend_controller

Parametrised vending-machine controller that accumulates coin credit, tracks per-product stock, and vends a selected product. After a vend it returns change in one pulse. It absorbs the coin-counting, product-selection and discount functions into one sequential block with a handshake-style pulse interface toward the coin mechanism and dispenser. It sits between the coin acceptor front end and the dispenser/change-hopper drivers.

## Interface
Parameters:
- N_PRODUCTS, 8, number of product slots (2..16)
- CREDIT_W, 16, credit/price/change width
- STOCK_W, 8, per-slot stock counter width
- PRICE_STEP, 500, base price of slot i = (i+1)*PRICE_STEP
- INIT_STOCK, 10, stock of every slot after reset
- CREDIT_MAX, 20000, maximum credit that may be held
- DISCOUNT_THRESH, 10, discount applies when stock > this value

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high
- coin_valid  in  1  coin presented this cycle
- coin_type  in  2  0=500, 1=1000, 2=2000, 3=5000
- coin_accept  out  1  one-cycle pulse: coin credited
- coin_reject  out  1  one-cycle pulse: coin returned
- sel_valid  in  1  selection request
- sel_addr  in  $clog2(N_PRODUCTS)  slot index
- cancel  in  1  refund request
- restock_valid  in  1  add stock
- restock_addr  in  $clog2(N_PRODUCTS)  slot to restock
- restock_qty  in  STOCK_W  quantity to add
- vend_valid  out  1  one-cycle dispense pulse
- vend_addr  out  $clog2(N_PRODUCTS)  slot dispensed, valid with vend_valid
- change_valid  out  1  one-cycle change pulse
- change_amount  out  CREDIT_W  change value, valid with change_valid
- err_valid  out  1  one-cycle error pulse
- err_code  out  2  1=sold out, 2=insufficient credit, 3=invalid address
- credit  out  CREDIT_W  current credit
- busy  out  1  high in VEND and CHANGE

## Operation
- States: IDLE (credit==0), HOLD (credit>0), VEND, CHANGE.
- Input priority per cycle in IDLE/HOLD: cancel > sel_valid > coin_valid.
- Coin handling:
  - Coin alone: credit+value <= CREDIT_MAX → credit += value, coin_accept. Otherwise → coin_reject, credit unchanged.
  - Coin together with cancel or sel_valid, or while busy → coin_reject.
- Selection, evaluated on registered credit and stock; effective price is from the price calculator:
  - sel_addr >= N_PRODUCTS → err code 3.
  - Else stock==0 → code 1.
  - Else credit < price → code 2.
  - On any error: state and credit unchanged.
  - Otherwise: stock[addr]−1, credit −= price, next state VEND.
- VEND: vend_valid=1 and vend_addr=addr; next state CHANGE.
- CHANGE:
  - credit>0 → change_valid=1, change_amount=credit, credit←0.
  - credit==0 → no pulse.
  - Next state IDLE.
- cancel in HOLD → CHANGE (full refund). cancel in IDLE has no effect. cancel while busy is ignored.
- Restock is accepted in every state:
  - stock[addr] += qty, saturating at 2^STOCK_W−1.
  - If the same slot is decremented by a selection in the same cycle, the net result is stock−1+qty, saturated.
  - Out-of-range restock_addr is ignored.
- Reset: state IDLE, credit 0, all stock = INIT_STOCK, all outputs 0. Reset mid-vend drops the vend and change pulses.

## Timing
- All outputs are registered.
- Coin at edge t → coin_accept/coin_reject and updated credit visible after edge t (cycle t+1).
- sel_valid at cycle t → vend_valid in cycle t+1, change_valid in cycle t+2, credit 0 in cycle t+3. Error pulses appear in cycle t+1.
- cancel at cycle t → change_valid in cycle t+1.
- busy is high for exactly 2 cycles per vend and 1 cycle per cancel.

## Configuration
- VEND_DISCOUNT_EN defined: when stock[addr] > DISCOUNT_THRESH, price = ceil(base*9/16), computed with a 2·CREDIT_W-bit product.
- VEND_DISCOUNT_EN undefined: price = base price always; the discount logic and DISCOUNT_THRESH are unused.

## Structure
- vend_pkg: coin_type encoding, coin value constants, state enum, err_code constants.
- Sub-module vend_price_calc: combinational; inputs are slot index and stock; output is effective price, including the macro-gated discount.

## Test plan
- Reset, then coins 500, 1000, 2000, 5000 → four coin_accept pulses, credit 8500, no reject.
- Credit 2000, select slot 2 (1500) → vend_valid addr 2 at t+1, change 500 at t+2, stock[2]=9, credit 0.
- Credit 1000, select slot 3 (2000) → err code 2, credit 1000; then cancel → change_valid 1000, state IDLE.
- INIT_STOCK=1: vend slot 0 twice with 500 credit each → second request gives err code 1, credit remains 500. Coin together with sel_valid → coin_reject.
- Credit 19000, insert 5000 → coin_reject, credit 19000; insert 1000 → accept, credit 20000.
- Restock slot 0 by 5 (stock 15), credit 500, select slot 0:
  - VEND_DISCOUNT_EN defined → price 282, change 218.
  - VEND_DISCOUNT_EN undefined → price 500, no change_valid.
